// File: rtl/sum_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sum_scheduler
// Purpose  : Time-multiplexed signed adder controller. One vector of IN_TERMS
//            signed terms is captured per handshake and reduced LANES terms
//            per cycle into a full-precision accumulator. The total comes back
//            on a ready/valid output, either clamped or wrapped to OUT_BITS.
// Ports    : clk        - system clock, rising edge
//            rst_n      - synchronous active-low reset
//            in         - IN_TERMS signed input terms
//            in_valid   - input vector valid
//            in_ready   - block accepts the input vector this cycle
//            out        - signed OUT_BITS result
//            out_sat    - result was clamped
//            out_valid  - out / out_sat valid
//            out_ready  - downstream accepts the result
// Revision : 1.0 - initial release
// ============================================================================
module sum_scheduler #(
    parameter int IN_BITS  = 8,
    parameter int IN_TERMS = 16,
    parameter int LANES    = 4,
    parameter int OUT_BITS = 14,
    parameter int SATURATE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [IN_BITS-1:0]  in [IN_TERMS],
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [OUT_BITS-1:0] out,
    output logic                       out_sat,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int NCHUNK   = (IN_TERMS + LANES - 1) / LANES;
    localparam int ACC_BITS = IN_BITS + $clog2(IN_TERMS) + 1;
    localparam int IDX_BITS = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PAD      = NCHUNK * LANES;
    localparam int POS_BITS = (PAD > 1) ? $clog2(PAD) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                     state;
    logic signed [IN_BITS-1:0]  bank [IN_TERMS];
    logic signed [IN_BITS-1:0]  lane_term [PAD];
    logic signed [ACC_BITS-1:0] acc;
    logic signed [ACC_BITS-1:0] acc_next;
    logic signed [ACC_BITS-1:0] chunk_sum;
    logic signed [ACC_BITS-1:0] ext;
    logic [POS_BITS-1:0]        pos;
    logic [IDX_BITS-1:0]        idx;
    logic signed [OUT_BITS-1:0] res_val;
    logic                       res_sat;

    // Pad the term bank to a whole number of chunks; the pad slots are tied
    // to zero so the last, partial chunk needs no special handling.
    for (genvar g = 0; g < PAD; g++) begin : g_lane
        if (g < IN_TERMS) begin : g_real
            assign lane_term[g] = bank[g];
        end else begin : g_zero
            assign lane_term[g] = '0;
        end
    end

    always_comb begin
        chunk_sum = '0;
        pos       = '0;
        ext       = '0;
        for (int l = 0; l < LANES; l++) begin
            pos       = POS_BITS'(int'(idx) * LANES + l);
            ext       = {{(ACC_BITS-IN_BITS){lane_term[pos][IN_BITS-1]}}, lane_term[pos]};
            chunk_sum = chunk_sum + ext;
        end
    end

    assign acc_next = acc + chunk_sum;

    // Result formation is taken from acc_next so the final chunk and the
    // output register share one edge.
    if (OUT_BITS >= ACC_BITS) begin : g_res_ext
        assign res_val = OUT_BITS'(acc_next);
        assign res_sat = 1'b0;
    end else if (SATURATE != 0) begin : g_res_sat
        localparam logic signed [ACC_BITS-1:0] MAX_V = ACC_BITS'((64'sd1 <<< (OUT_BITS-1)) - 64'sd1);
        localparam logic signed [ACC_BITS-1:0] MIN_V = ACC_BITS'(-(64'sd1 <<< (OUT_BITS-1)));
        always_comb begin
            res_val = acc_next[OUT_BITS-1:0];
            res_sat = 1'b0;
            if (acc_next > MAX_V) begin
                res_val = {1'b0, {(OUT_BITS-1){1'b1}}};
                res_sat = 1'b1;
            end else if (acc_next < MIN_V) begin
                res_val = {1'b1, {(OUT_BITS-1){1'b0}}};
                res_sat = 1'b1;
            end
        end
    end else begin : g_res_wrap
        assign res_val = acc_next[OUT_BITS-1:0];
        assign res_sat = 1'b0;
    end

    // In DONE the slot frees up in the same cycle the result is taken, which
    // allows back-to-back vectors without an IDLE bubble.
    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            idx       <= '0;
            out       <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
            for (int i = 0; i < IN_TERMS; i++) begin
                bank[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        bank  <= in;
                        acc   <= '0;
                        idx   <= '0;
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc <= acc_next;
                    if (idx == LAST_IDX) begin
                        out       <= res_val;
                        out_sat   <= res_sat;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            bank  <= in;
                            acc   <= '0;
                            idx   <= '0;
                            state <= S_ACCUM;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sum_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_scheduler
// Purpose  : Self-checking bench for sum_scheduler. A default instance plus
//            three re-parameterised instances (8-bit saturating, 8-bit
//            wrapping, 10-term) are driven with directed vectors; expected
//            results are queued at issue time and popped by per-instance
//            monitors whenever a result is transferred.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_scheduler;

    typedef struct {
        int val;
        int sat;
    } exp_t;

    logic clk;
    logic rst_n;

    // default instance
    logic signed [7:0]  m_in [16];
    logic               m_in_valid, m_in_ready;
    logic signed [13:0] m_out;
    logic               m_out_sat, m_out_valid, m_out_ready;

    // re-parameterised instances
    logic signed [7:0]  s_in [16];
    logic signed [7:0]  t_in [10];
    logic               side_valid;
    logic               s8_in_ready, w8_in_ready, t10_in_ready;
    logic signed [7:0]  s8_out, w8_out;
    logic signed [13:0] t10_out;
    logic               s8_sat, w8_sat, t10_sat;
    logic               s8_valid, w8_valid, t10_valid;

    int tests = 0;
    int fails = 0;
    exp_t q_main[$], q_s8[$], q_w8[$], q_t10[$];

    sum_scheduler dut (
        .clk(clk), .rst_n(rst_n), .in(m_in), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .out(m_out), .out_sat(m_out_sat), .out_valid(m_out_valid), .out_ready(m_out_ready)
    );

    sum_scheduler #(.OUT_BITS(8), .SATURATE(1)) dut_s8 (
        .clk(clk), .rst_n(rst_n), .in(s_in), .in_valid(side_valid), .in_ready(s8_in_ready),
        .out(s8_out), .out_sat(s8_sat), .out_valid(s8_valid), .out_ready(1'b1)
    );

    sum_scheduler #(.OUT_BITS(8), .SATURATE(0)) dut_w8 (
        .clk(clk), .rst_n(rst_n), .in(s_in), .in_valid(side_valid), .in_ready(w8_in_ready),
        .out(w8_out), .out_sat(w8_sat), .out_valid(w8_valid), .out_ready(1'b1)
    );

    sum_scheduler #(.IN_TERMS(10)) dut_t10 (
        .clk(clk), .rst_n(rst_n), .in(t_in), .in_valid(side_valid), .in_ready(t10_in_ready),
        .out(t10_out), .out_sat(t10_sat), .out_valid(t10_valid), .out_ready(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin : mon_main
        exp_t e;
        if (rst_n && m_out_valid && m_out_ready) begin
            if (q_main.size() == 0) check("main_unexpected_out", 1, 0);
            else begin
                e = q_main.pop_front();
                check("main_out", int'(m_out), e.val);
                check("main_sat", int'(m_out_sat), e.sat);
            end
        end
    end

    always @(negedge clk) begin : mon_s8
        exp_t e;
        if (rst_n && s8_valid) begin
            if (q_s8.size() == 0) check("s8_unexpected_out", 1, 0);
            else begin
                e = q_s8.pop_front();
                check("s8_out", int'(s8_out), e.val);
                check("s8_sat", int'(s8_sat), e.sat);
            end
        end
    end

    always @(negedge clk) begin : mon_w8
        exp_t e;
        if (rst_n && w8_valid) begin
            if (q_w8.size() == 0) check("w8_unexpected_out", 1, 0);
            else begin
                e = q_w8.pop_front();
                check("w8_out", int'(w8_out), e.val);
                check("w8_sat", int'(w8_sat), e.sat);
            end
        end
    end

    always @(negedge clk) begin : mon_t10
        exp_t e;
        if (rst_n && t10_valid) begin
            if (q_t10.size() == 0) check("t10_unexpected_out", 1, 0);
            else begin
                e = q_t10.pop_front();
                check("t10_out", int'(t10_out), e.val);
                check("t10_sat", int'(t10_sat), e.sat);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic fill_main(input int v);
        for (int i = 0; i < 16; i++) m_in[i] = 8'(v);
    endtask

    // Queue the expectation, hold in_valid until accepted, then drop it.
    // Returns #1 after the capture edge.
    task automatic issue(input int ev, input int es);
        exp_t e;
        int n;
        e.val = ev;
        e.sat = es;
        q_main.push_back(e);
        m_in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!m_in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!m_in_ready) check("issue_timeout", 0, 1);
        @(posedge clk); #1;
        m_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_main.size() + q_s8.size() + q_w8.size() + q_t10.size()) > 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin : stim
        exp_t e;
        int n;
        rst_n       = 1'b0;
        m_in_valid  = 1'b0;
        m_out_ready = 1'b1;
        side_valid  = 1'b0;
        fill_main(0);
        for (int i = 0; i < 16; i++) s_in[i] = 8'sd0;
        for (int i = 0; i < 10; i++) t_in[i] = 8'sd0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(m_in_ready), 1);
        check("rst_out_valid", int'(m_out_valid), 0);
        check("rst_out", int'(m_out), 0);
        check("rst_out_sat", int'(m_out_sat), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // all ones: latency, in_ready drop, input ignored after capture
        fill_main(1);
        issue(16, 0);
        fill_main(9);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) check("ones_in_ready_drop", int'(m_in_ready), 0);
            check("ones_latency_valid", int'(m_out_valid), (k == 4) ? 1 : 0);
        end
        drain();

        // most negative terms and mixed signs
        fill_main(-128);
        issue(-2048, 0);
        drain();
        for (int i = 0; i < 16; i++) m_in[i] = 8'(i - 8);
        issue(-8, 0);
        drain();

        // backpressure with a new vector waiting
        m_out_ready = 1'b0;
        fill_main(3);
        issue(48, 0);
        n = 0;
        @(negedge clk);
        while (!m_out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("bp_valid_seen", int'(m_out_valid), 1);
        fill_main(5);
        e.val = 80;
        e.sat = 0;
        q_main.push_back(e);
        m_in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", int'(m_out_valid), 1);
            check("bp_hold_out", int'(m_out), 48);
            check("bp_hold_in_ready", int'(m_in_ready), 0);
        end
        @(posedge clk); #1;
        m_out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", int'(m_in_ready), 1);
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check("bp_b2b_valid", int'(m_out_valid), (k == 4) ? 1 : 0);
        end
        drain();

        // saturating / wrapping 8-bit outputs and 10-term padding
        for (int i = 0; i < 16; i++) s_in[i] = 8'sd127;
        for (int i = 0; i < 10; i++) t_in[i] = 8'(i + 1);
        e.val = 127; e.sat = 1; q_s8.push_back(e);
        e.val = -16; e.sat = 0; q_w8.push_back(e);
        e.val = 55;  e.sat = 0; q_t10.push_back(e);
        side_valid = 1'b1;
        @(posedge clk); #1;
        side_valid = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check("t10_latency_valid", int'(t10_valid), (k == 3) ? 1 : 0);
            check("s8_latency_valid", int'(s8_valid), (k == 4) ? 1 : 0);
        end
        drain();

        // reset during the second accumulation cycle
        fill_main(7);
        m_in_valid = 1'b1;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", int'(m_out_valid), 0);
        check("midrst_out", int'(m_out), 0);
        check("midrst_in_ready", int'(m_in_ready), 1);
        fill_main(2);
        issue(32, 0);
        drain();

        repeat (3) @(posedge clk);
        check("leftover_main", q_main.size(), 0);
        check("leftover_side", q_s8.size() + q_w8.size() + q_t10.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sum_scheduler.md
Name: sum_scheduler

Overview:
- Time-multiplexed controller for a LANES-input signed adder. It accumulates a vector of IN_TERMS signed terms over several clock cycles.
- It captures one input vector per handshake and sequences it through the adder LANES terms per cycle.
- The accumulated total is returned on a ready/valid output, with optional saturation.
- Used in the emulated link datapath (FFE/DFE tap sums) wherever a full-width single-cycle adder tree does not meet area or timing.

Parameters:
- IN_BITS, 8: width of each signed input term.
- IN_TERMS, 16: number of terms per input vector.
- LANES, 4: terms summed per clock cycle.
- OUT_BITS, 14: width of the signed result.
- SATURATE, 1: 1 = clamp the result to the OUT_BITS range; 0 = keep the low OUT_BITS bits (two's-complement wrap).

Ports:
- clk, input, 1: system clock, all logic on the rising edge.
- rst_n, input, 1: synchronous active-low reset.
- in, input, signed [IN_BITS-1:0] x [IN_TERMS-1:0]: unpacked array of input terms.
- in_valid, input, 1: the `in` vector is valid.
- in_ready, output, 1: block accepts `in` this cycle.
- out, output, signed [OUT_BITS-1:0]: accumulated sum.
- out_sat, output, 1: result was clamped (always 0 when SATURATE=0).
- out_valid, output, 1: `out` and `out_sat` are valid.
- out_ready, input, 1: downstream accepts the output.

Behaviour:
- Constants:
  - NCHUNK = ceil(IN_TERMS/LANES).
  - ACC_BITS = IN_BITS + clog2(IN_TERMS) + 1. The accumulator is full precision and never overflows internally.
- Reset (rst_n=0 at a clock edge), from any state including mid-accumulation:
  - state=IDLE, in_ready=1, out_valid=0, out=0, out_sat=0.
  - Accumulator and chunk index cleared.
  - Any captured vector is discarded.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - capture all terms into a term register bank;
    - set acc=0 and idx=0;
    - go to ACCUM.
  - ACCUM: in_ready=0. Each cycle:
    - acc += sign-extended sum of captured terms idx*LANES .. idx*LANES+LANES-1;
    - term positions >= IN_TERMS contribute 0;
    - idx++.
    - When idx==NCHUNK-1 is processed, go to DONE and register the result. out_valid=1 on the next cycle.
  - DONE: out_valid=1 and out/out_sat hold stable until out_ready=1.
    - in_ready = out_ready in this state.
    - out_valid&&out_ready with in_valid=1: the new vector is captured in the same cycle, next state is ACCUM (back-to-back, no IDLE bubble).
    - out_valid&&out_ready with in_valid=0: next state is IDLE.
- Latency:
  - Capture at edge 0; accumulation occupies edges 1..NCHUNK; out_valid is high after edge NCHUNK.
  - Throughput is one vector per NCHUNK+1 cycles with continuous out_ready.
- Input timing: `in` is sampled only at the capture edge. Input changes at any other time have no effect.
- Result formation from the final acc:
  - SATURATE=1:
    - acc > 2^(OUT_BITS-1)-1 gives out = max, out_sat=1;
    - acc < -2^(OUT_BITS-1) gives out = min, out_sat=1;
    - otherwise out = acc, out_sat=0.
  - SATURATE=0: out = acc[OUT_BITS-1:0], out_sat=0.
  - OUT_BITS >= ACC_BITS: out is the sign-extended acc.
- Degenerate parameters:
  - LANES >= IN_TERMS: NCHUNK=1 (single ACCUM cycle).
  - LANES=1: fully serial operation.
- Handshake rules:
  - out_valid never deasserts without out_ready.
  - in_valid may deassert without being accepted.
  - in_ready is low for the entire ACCUM state.

Test Plan:
- Defaults: all 16 terms = 1, out_ready=1.
  - Required: in_ready drops the cycle after capture.
  - Required: out_valid high 4 cycles after capture with out=16, out_sat=0.
- Defaults: all terms = -128 -> out=-2048, out_sat=0. Mixed terms k-8 for k=0..15 -> out=-8.
- OUT_BITS=8, SATURATE=1, all terms 127 (sum 2032) -> out=127, out_sat=1. Same stimulus with SATURATE=0 -> out=-16 (2032 mod 256 = 240), out_sat=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and present in_valid=1 with a new vector.
  - Required: out stable, out_valid=1, in_ready=0 throughout.
  - Required: when out_ready=1, the new vector is accepted in that same cycle and its result follows 4 cycles later.
- IN_TERMS=10, LANES=4: terms 1..10 -> NCHUNK=3, out=55 three cycles after capture. The padded positions 10 and 11 contribute 0.
- Reset mid-operation: assert rst_n=0 during the second ACCUM cycle.
  - Required after the reset edge: out_valid=0, out=0, in_ready=1.
  - Required: the next vector of all 2s yields out=32 with no residue from the aborted sum.
